// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: op encoding, FSM states, error codes
// and the op -> access size / signedness mapping.
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  typedef struct packed {
    size_t size;
    logic  sgn;
    logic  store;
  } op_info_t;

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic op_info_t op_info(input logic [2:0] op);
    op_info.size  = op_size(op);
    op_info.sgn   = (op == OP_LB) || (op == OP_LH);
    op_info.store = (op >= OP_SB);
  endfunction

  function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: lane_replicate = {4{d[7:0]}};
      SZ_HALF: lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational lane select and sign/zero extension of a little-endian read word;
// zero latency, no flow control. Stores yield 0.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  op_info_t    info;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    info   = op_info(op);
    sel_b  = word[{addr_lo, 3'b000} +: 8];
    sel_h  = word[{addr_lo[1], 4'b0000} +: 16];
    result = 32'd0;
    if (!info.store) begin
      case (info.size)
        SZ_BYTE: result = {{24{info.sgn & sel_b[7]}}, sel_b};
        SZ_HALF: result = {{16{info.sgn & sel_h[15]}}, sel_h};
        default: result = word;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// One-at-a-time load/store sequencer: align check, word-aligned memory request, timed ack wait.
// Latency >= 2 cycles (1 when misaligned); stalls the pipeline and refuses requests while busy.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] load_word;
  size_t       sz_in;
  logic        accept, misalign_in, timeout;

  assign sz_in       = op_size(req_op);
  assign accept      = req_valid && (state == ST_IDLE);
  assign misalign_in = ((sz_in == SZ_HALF) && req_addr[0]) ||
                       ((sz_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign timeout     = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs decode the state register directly so reset clears them at once.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    stall     = 1'b1;
    mem_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (accept) state_nxt = misalign_in ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack || timeout) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 8'd0;
      op_q      <= OP_LB;
      lane_q    <= 2'b00;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      if (state != ST_ACCESS) wait_cnt <= 8'd0;
      else if (!mem_ack)      wait_cnt <= wait_cnt + 8'd1;
      if (accept) begin
        op_q      <= req_op;
        lane_q    <= req_addr[1:0];
        mem_we    <= (req_op >= OP_SB);
        mem_be    <= byte_en(sz_in, req_addr[1:0]);
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= lane_replicate(sz_in, req_wdata);
      end
    end
  end

  lsu_load_extend u_load_extend (
    .op      (op_q),
    .addr_lo (lane_q),
    .word    (mem_rdata),
    .result  (load_word)
  );

  // Response fields are only non-zero during the single RESP cycle; ack beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= ERR_OK;
      if (accept && misalign_in) begin
        resp_valid <= 1'b1;
        resp_err   <= ERR_MISALIGN;
      end else if (state == ST_ACCESS) begin
        if (mem_ack) begin
          resp_valid <= 1'b1;
          resp_rdata <= load_word;
        end else if (timeout) begin
          resp_valid <= 1'b1;
          resp_err   <= ERR_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short timeout window so the wait bound is reachable.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  lsu_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;   // cycle after accept carrying the ack; 0 = never
    int          lat;
    int          reqc;
    logic [31:0] rd;
    logic [1:0]  err;
    logic [3:0]  be;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_at,
                           output int lat, output int reqc, output logic [31:0] rd,
                           output logic [1:0] err, output logic [3:0] be, output logic we,
                           output logic [31:0] maddr, output logic [31:0] mwdata,
                           output logic stall_after);
    bit got = 0;
    lat = -1; reqc = 0; rd = 'x; err = 'x; be = 'x; we = 'x; maddr = 'x; mwdata = 'x;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c < 300 && !got; c++) begin
      if (resp_valid) begin
        lat = c; rd = resp_rdata; err = resp_err; got = 1;
      end else begin
        if (mem_req) begin
          if (reqc == 0) begin
            be = mem_be; we = mem_we; maddr = mem_addr; mwdata = mem_wdata;
          end
          reqc++;
        end
        mem_ack   = (c == ack_at);
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
    @(posedge clk); #1;
    stall_after = stall;
  endtask

  initial begin
    int lat, reqc;
    logic [31:0] rd, maddr, mwdata;
    logic [1:0] err;
    logic [3:0] be;
    logic we, st_after;

    vecs[0]  = '{OP_LB,  32'h1003, 32'h0,         32'h80FF_0000, 1, 2, 1, 32'hFFFF_FF80, ERR_OK,       4'b1000, 1'b0, 32'h1000, 32'h0};
    vecs[1]  = '{OP_LHU, 32'h2002, 32'h0,         32'h8001_1234, 1, 2, 1, 32'h0000_8001, ERR_OK,       4'b1100, 1'b0, 32'h2000, 32'h0};
    vecs[2]  = '{OP_SB,  32'h3001, 32'h1234_56AB, 32'hFFFF_FFFF, 2, 3, 2, 32'h0,         ERR_OK,       4'b0010, 1'b1, 32'h3000, 32'hABAB_ABAB};
    vecs[3]  = '{OP_LW,  32'h4002, 32'h0,         32'h0,         1, 1, 0, 32'h0,         ERR_MISALIGN, 4'b0,    1'b0, 32'h0,    32'h0};
    vecs[4]  = '{OP_SH,  32'h4001, 32'h0,         32'h0,         1, 1, 0, 32'h0,         ERR_MISALIGN, 4'b0,    1'b0, 32'h0,    32'h0};
    vecs[5]  = '{OP_LH,  32'h5000, 32'h0,         32'h1234_F00F, 1, 2, 1, 32'hFFFF_F00F, ERR_OK,       4'b0011, 1'b0, 32'h5000, 32'h0};
    vecs[6]  = '{OP_LBU, 32'h6002, 32'h0,         32'h00C3_0000, 3, 4, 3, 32'h0000_00C3, ERR_OK,       4'b0100, 1'b0, 32'h6000, 32'h0};
    vecs[7]  = '{OP_LW,  32'h7004, 32'h0,         32'hDEAD_BEEF, 1, 2, 1, 32'hDEAD_BEEF, ERR_OK,       4'b1111, 1'b0, 32'h7004, 32'h0};
    vecs[8]  = '{OP_SH,  32'h8002, 32'hAAAA_5678, 32'h0,         1, 2, 1, 32'h0,         ERR_OK,       4'b1100, 1'b1, 32'h8000, 32'h5678_5678};
    vecs[9]  = '{OP_SW,  32'h9000, 32'hCAFE_F00D, 32'h0,         1, 2, 1, 32'h0,         ERR_OK,       4'b1111, 1'b1, 32'h9000, 32'hCAFE_F00D};
    vecs[10] = '{OP_LW,  32'hA000, 32'h0,         32'h1122_3344, 0, 5, 4, 32'h0,         ERR_TIMEOUT,  4'b1111, 1'b0, 32'hA000, 32'h0};
    vecs[11] = '{OP_LW,  32'hA000, 32'h0,         32'h1122_3344, 4, 5, 4, 32'h1122_3344, ERR_OK,       4'b1111, 1'b0, 32'hA000, 32'h0};
    vecs[12] = '{OP_LB,  32'hB001, 32'h0,         32'h0000_7F00, 1, 2, 1, 32'h0000_007F, ERR_OK,       4'b0010, 1'b0, 32'hB000, 32'h0};
    vecs[13] = '{OP_LHU, 32'hC003, 32'h0,         32'h0,         1, 1, 0, 32'h0,         ERR_MISALIGN, 4'b0,    1'b0, 32'h0,    32'h0};

    rst_n = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_stall",      {31'd0, stall},      32'd0);
    check("rst_mem_req",    {31'd0, mem_req},    32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_be",     {28'd0, mem_be},     32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_resp_err",   {30'd0, resp_err},   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      do_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].ack_at,
                lat, reqc, rd, err, be, we, maddr, mwdata, st_after);
      check($sformatf("v%0d_latency", i),   lat,  vecs[i].lat);
      check($sformatf("v%0d_req_cycles", i), reqc, vecs[i].reqc);
      check($sformatf("v%0d_rdata", i),     rd,   vecs[i].rd);
      check($sformatf("v%0d_err", i),       {30'd0, err}, {30'd0, vecs[i].err});
      check($sformatf("v%0d_stall_after", i), {31'd0, st_after}, 32'd0);
      if (vecs[i].reqc != 0) begin
        check($sformatf("v%0d_be", i),     {28'd0, be}, {28'd0, vecs[i].be});
        check($sformatf("v%0d_we", i),     {31'd0, we}, {31'd0, vecs[i].we});
        check($sformatf("v%0d_maddr", i),  maddr,  vecs[i].maddr);
        check($sformatf("v%0d_mwdata", i), mwdata, vecs[i].mwdata);
      end
    end

    // Ack while idle must not produce a response.
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("idle_ack_no_resp", {31'd0, resp_valid}, 32'd0);
    check("idle_ack_no_stall", {31'd0, stall}, 32'd0);

    // Reset in the second ACCESS cycle, then a stray ack after release.
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'hD000; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_access1_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    check("mid_access2_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req",    {31'd0, mem_req},    32'd0);
    check("arst_stall",      {31'd0, stall},      32'd0);
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_resp1", {31'd0, resp_valid}, 32'd0);
    check("stray_ack_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("stray_ack_resp2", {31'd0, resp_valid}, 32'd0);

    do_access(OP_LW, 32'hE000, 32'd0, 32'h5A5A_1234, 1, lat, reqc, rd, err, be, we, maddr, mwdata, st_after);
    check("post_rst_latency", lat, 2);
    check("post_rst_rdata",   rd,  32'h5A5A_1234);
    check("post_rst_err",     {30'd0, err}, 32'd0);
    check("post_rst_maddr",   maddr, 32'hE000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the pipeline's MEM stage and the data-memory/cache port. It accepts one load or store at a time, checks alignment, and drives a word-aligned memory request with byte enables. It waits for the memory acknowledge with a bounded timeout, then returns lane-selected, sign- or zero-extended load data. While it is busy it stalls the pipeline.

## Interface
- `MAX_WAIT`, 255: cycles `mem_req` may stay high without `mem_ack` before a timeout error (1..255).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: MEM stage has an access.
- `req_ready` out 1: high only in IDLE; a request is accepted on `req_valid & req_ready`.
- `req_op` in 3: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte, halfword or word is used.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 2: 0 ok, 1 misaligned, 2 timeout.
- `stall` out 1: high whenever the state is not IDLE.
- `mem_req` out 1: memory request, held high until ack or timeout.
- `mem_we` out 1: 1 for stores.
- `mem_be` out 4: byte enables; bit i selects `addr[1:0]==i`.
- `mem_addr` out 32: `{req_addr[31:2],2'b00}`.
- `mem_wdata` out 32: store data replicated across lanes (byte ×4, halfword ×2).
- `mem_ack` in 1: memory done; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - On accept, register op, addr and wdata.
  - A halfword access with `addr[0]=1`, or a word access with `addr[1:0]≠0`, is misaligned: go to RESP with err=1 and issue no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_req`=1. The wait counter resets to 0 on entry and increments each cycle without ack.
  - On `mem_ack`: capture the load result and go to RESP with err=0.
  - When the counter equals `MAX_WAIT-1` with no ack: go to RESP with err=2 and `mem_req` drops.
  - If ack and timeout occur in the same cycle, the ack wins.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE. There is no backpressure; the consumer must take the response.
- Byte enables:
  - Byte accesses: one-hot on `addr[1:0]`.
  - Halfword accesses: 0011 when `addr[1]=0`, 1100 when `addr[1]=1`.
  - Word accesses: 1111.
  - Loads drive the same `mem_be`, and `mem_we`=0.
- Load extraction (little-endian):
  - Select the byte `mem_rdata[8*a+7:8*a]` or the halfword `mem_rdata[16*a1+15:16*a1]`.
  - LB and LH sign-extend the top bit to 32 bits; LBU and LHU zero-extend; LW passes the word through.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Accept at cycle T gives `mem_req` high from T+1. If the ack arrives at cycle T+k, `resp_valid` is high at T+k+1.
  - Minimum latency is 2 cycles (ack at T+1, response at T+2).
- Misaligned access accepted at T gives `resp_valid` at T+1 with no `mem_req` pulse.
- Timeout: `mem_req` is high for exactly `MAX_WAIT` cycles, then `resp_valid` follows on the next cycle.
- All `mem_*` outputs come from registered state and are stable while `mem_req` is high.
- `resp_*` outputs are registered.
- Reset asserted mid-ACCESS drops `mem_req` and `stall` immediately (asynchronously). An in-flight ack after release is ignored.
- Back-to-back requests: the next accept happens in the IDLE cycle after RESP. The throughput ceiling is one access per 3 cycles.

## Structure
- Package `lsu_pkg` holds:
  - op encoding constants;
  - state enum (IDLE, ACCESS, RESP);
  - `resp_err` codes;
  - a function mapping op to size and signedness.
- Sub-module `lsu_load_extend`: combinational lane select plus sign/zero extension. Inputs are op, `addr[1:0]` and the 32-bit word; output is the 32-bit result. It is reused by the writeback path.

## Test plan
- LB at 0x1003, `mem_rdata`=0x80FF_0000, ack after 1 cycle → `resp_rdata`=0xFFFF_FF80, err 0, `resp_valid` at T+2.
- LHU at 0x2002, `mem_rdata`=0x8001_1234 → `mem_be`=1100, `mem_addr`=0x2000, `resp_rdata`=0x0000_8001.
- SB at 0x3001, wdata=0x1234_56AB → `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xABAB_ABAB, `resp_rdata`=0.
- LW at 0x4002 → no `mem_req`, `resp_valid` at T+1, err=1. SH at 0x4001 → err=1.
- With `MAX_WAIT`=4 and mem_ack held low → `mem_req` high for 4 cycles, then `resp_err`=2 and `stall` low the cycle after RESP. Repeat with ack arriving in the 4th cycle → err 0.
- `rst_n` pulled low in the 2nd ACCESS cycle → `mem_req`, `stall` and `resp_valid` are 0 immediately. A spurious ack after release produces no response, and the next LW completes normally.
